carry_chain_pipe: RTL and testbench

- Parametrised successor to the single-bit carry follower primitive: a WIDTH-bit ripple adder/subtractor built from per-bit carry-follower muxes.
- Carry rule per bit: c[i+1] = c[i] ? p[i] : g[i].
- The chain is split into SEG-bit segments with a pipeline register between segments, plus a valid/ready handshake.
- Sits in the CLB arithmetic path and implements fabric-level hard adders for wide operands.

---
 rtl/carry_chain_pipe.sv | 148 ++++++++++++++
 tb/tb_carry_chain_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_chain_pipe.sv
// carry_chain_pipe: pipelined WIDTH-bit adder/subtractor built from per-bit
// carry-follower muxes (c[i+1] = c[i] ? p[i] : g[i]). The chain is cut into
// SEG-bit segments with one register stage per segment. A valid/ready
// handshake with a single global advance enable moves the whole pipe.
//
// Ports:
//   clk        fabric clock, rising edge
//   reset      synchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   pipe can accept a beat this cycle
//   op         00 add, 01 add+carry_in, 10 a-b, 11 a-b with carry_in (1 = no borrow)
//   a, b       operands
//   carry_in   external carry, used for op 01/11 only
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result bits (modulo 2^WIDTH)
//   cout       carry out of MSB (1 = no borrow for subtract)
//   ovf        signed overflow
//   zero       sum == 0 (qualified by out_valid)
module carry_chain_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSTG = WIDTH / SEG;
  localparam int unsigned LAST = NSTG - 1;

  if ((WIDTH % SEG) != 0) begin : g_param_check
    $error("carry_chain_pipe: WIDTH must be a multiple of SEG");
  end

  // Global advance enable: the pipe moves unless a result is stuck at the output.
  logic             en;
  logic [WIDTH-1:0] y_in;
  logic             c0;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Operand prep: invert b for subtract; carry seed is 0/1 for plain ops, carry_in otherwise.
  assign y_in = op[1] ? ~b : b;
  assign c0   = op[0] ? carry_in : op[1];

  // Stage registers; stage k holds the result of resolving segment k.
  logic             vld_q  [NSTG];
  logic [WIDTH-1:0] a_q    [NSTG];
  logic [WIDTH-1:0] y_q    [NSTG];
  logic [WIDTH-1:0] sum_q  [NSTG];
  logic             cy_q   [NSTG];
  logic             cmsb_q [NSTG];

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int unsigned LO = k * SEG;

    logic             src_vld;
    logic             src_c;
    logic             src_cmsb;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_y;
    logic [WIDTH-1:0] src_sum;
    logic [WIDTH-1:0] sum_d;
    logic             cmsb_d;
    logic [SEG:0]     c;

    // Stage input: operand prep for stage 0, previous stage register otherwise.
    if (k == 0) begin : g_src
      assign src_vld  = in_valid;
      assign src_a    = a;
      assign src_y    = y_in;
      assign src_sum  = '0;
      assign src_c    = c0;
      assign src_cmsb = 1'b0;
    end else begin : g_src
      assign src_vld  = vld_q[k-1];
      assign src_a    = a_q[k-1];
      assign src_y    = y_q[k-1];
      assign src_sum  = sum_q[k-1];
      assign src_c    = cy_q[k-1];
      assign src_cmsb = cmsb_q[k-1];
    end

    // Carry-follower chain across this segment.
    assign c[0] = src_c;
    for (genvar j = 0; j < SEG; j++) begin : g_bit
      assign c[j+1] = c[j] ? (src_a[LO+j] | src_y[LO+j]) : (src_a[LO+j] & src_y[LO+j]);
    end

    always_comb begin
      sum_d            = src_sum;
      sum_d[LO +: SEG] = src_a[LO +: SEG] ^ src_y[LO +: SEG] ^ c[SEG-1:0];
    end

    // Carry into bit WIDTH-1 is only produced by the top segment.
    if (k == LAST) begin : g_msb
      assign cmsb_d = c[SEG-1];
    end else begin : g_msb
      assign cmsb_d = src_cmsb;
    end

    // Bubbles advance with en; payload only loads for real beats.
    always_ff @(posedge clk) begin
      if (!reset) begin
        vld_q[k]  <= 1'b0;
        a_q[k]    <= '0;
        y_q[k]    <= '0;
        sum_q[k]  <= '0;
        cy_q[k]   <= 1'b0;
        cmsb_q[k] <= 1'b0;
      end else if (en) begin
        vld_q[k] <= src_vld;
        if (src_vld) begin
          a_q[k]    <= src_a;
          y_q[k]    <= src_y;
          sum_q[k]  <= sum_d;
          cy_q[k]   <= c[SEG];
          cmsb_q[k] <= cmsb_d;
        end
      end
    end
  end

  // Result flags derive from the last stage register only.
  assign out_valid = vld_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = cy_q[LAST];
  assign ovf       = cmsb_q[LAST] ^ cy_q[LAST];
  assign zero      = vld_q[LAST] && (sum_q[LAST] == '0);

  // Operand copies in the last stage have no consumer.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[LAST], y_q[LAST]};

endmodule

// File: tb/tb_carry_chain_pipe.sv
// Bench for carry_chain_pipe (WIDTH=8, SEG=4): directed handshake/latency
// scenarios followed by randomized traffic, all checked against an
// arithmetic reference model and an in-order expectation queue.
module tb_carry_chain_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SEG   = 4;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             z;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  exp_t q[$];
  int   tests;
  int   failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  carry_chain_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference: plain integer add/subtract, then reduce modulo 2^WIDTH.
  function automatic exp_t model(input logic [1:0] f_op, input logic [WIDTH-1:0] fa,
                                 input logic [WIDTH-1:0] fb, input logic fcin);
    exp_t e;
    int   cin;
    int   ur;
    int   sr;
    int   sa;
    int   sb;
    if (f_op == 2'b00)      cin = 0;
    else if (f_op == 2'b10) cin = 1;
    else                    cin = int'(fcin);
    sa = int'($signed(fa));
    sb = int'($signed(fb));
    if (!f_op[1]) begin
      ur  = int'(fa) + int'(fb) + cin;
      sr  = sa + sb + cin;
      e.c = (ur > 255);
    end else begin
      ur  = int'(fa) - int'(fb) - (1 - cin);
      sr  = sa - sb - (1 - cin);
      e.c = (ur >= 0);
    end
    e.s = WIDTH'(ur);
    e.v = (sr > 127) || (sr < -128);
    e.z = (e.s == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes before the edge, score pops, record accepted beats.
  task automatic cycle();
    logic             acc;
    logic             pop;
    logic             rst_s;
    logic [1:0]       s_op;
    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
    logic             s_cin;
    exp_t             e;
    #1;
    rst_s = reset;
    acc   = rst_s && in_valid && in_ready;
    pop   = rst_s && out_valid && out_ready;
    s_op  = op;
    s_a   = a;
    s_b   = b;
    s_cin = carry_in;
    if (pop === 1'b1) begin
      if (q.size() == 0) begin
        chk("extra_out_valid", 32'(out_valid), 32'(0));
      end else begin
        e = q.pop_front();
        chk("q_sum",  32'(sum),  32'(e.s));
        chk("q_cout", 32'(cout), 32'(e.c));
        chk("q_ovf",  32'(ovf),  32'(e.v));
        chk("q_zero", 32'(zero), 32'(e.z));
      end
    end
    @(posedge clk);
    if (rst_s !== 1'b1) q.delete();
    else if (acc === 1'b1) q.push_back(model(s_op, s_a, s_b, s_cin));
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] t_op, input logic [WIDTH-1:0] t_a,
                      input logic [WIDTH-1:0] t_b, input logic t_cin);
    in_valid = 1'b1;
    op       = t_op;
    a        = t_a;
    b        = t_b;
    carry_in = t_cin;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [WIDTH-1:0] s, input logic c,
                            input logic v, input logic z);
    chk({tag, "_valid"}, 32'(out_valid), 32'(1));
    chk({tag, "_sum"},   32'(sum),       32'(s));
    chk({tag, "_cout"},  32'(cout),      32'(c));
    chk({tag, "_ovf"},   32'(ovf),       32'(v));
    chk({tag, "_zero"},  32'(zero),      32'(z));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    failed    = 0;
    reset     = 1'b0;
    in_valid  = 1'b1;
    op        = 2'b00;
    a         = 8'h12;
    b         = 8'h34;
    carry_in  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset held two cycles with in_valid high.
    cycle();
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum",       32'(sum),       32'(0));
    chk("rst_cout",      32'(cout),      32'(0));
    chk("rst_ovf",       32'(ovf),       32'(0));
    chk("rst_zero",      32'(zero),      32'(0));
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));
    cycle();
    cycle();
    chk("idle_out_valid", 32'(out_valid), 32'(0));

    // Adds, with latency check on the first beat.
    send(2'b00, 8'hFF, 8'h01, 1'b0);
    chk("lat1_out_valid", 32'(out_valid), 32'(0));
    cycle();
    expect_out("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1);
    cycle();
    send(2'b00, 8'h7F, 8'h01, 1'b1);
    cycle();
    expect_out("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0);
    cycle();

    // Subtracts; carry_in must be ignored for op 10.
    send(2'b10, 8'h05, 8'h07, 1'b1);
    cycle();
    expect_out("sub_05_07", 8'hFE, 1'b0, 1'b0, 1'b0);
    cycle();
    send(2'b11, 8'h10, 8'h01, 1'b0);
    cycle();
    expect_out("sbc_10_01", 8'h0E, 1'b1, 1'b0, 1'b0);
    cycle();

    // Back-to-back beats, full throughput.
    send(2'b00, 8'h0F, 8'h01, 1'b0);
    send(2'b00, 8'hF0, 8'h10, 1'b0);
    expect_out("b2b_0", 8'h10, 1'b0, 1'b0, 1'b0);
    send(2'b00, 8'h80, 8'h80, 1'b0);
    expect_out("b2b_1", 8'h00, 1'b1, 1'b0, 1'b1);
    send(2'b00, 8'h01, 8'h01, 1'b0);
    expect_out("b2b_2", 8'h00, 1'b1, 1'b1, 1'b1);
    cycle();
    expect_out("b2b_3", 8'h02, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("b2b_done_valid", 32'(out_valid), 32'(0));

    // Stall with two beats in flight, a rejected third beat, then drain.
    out_ready = 1'b0;
    send(2'b00, 8'h21, 8'h10, 1'b0);
    send(2'b10, 8'h44, 8'h04, 1'b0);
    chk("stall_in_ready0", 32'(in_ready), 32'(0));
    expect_out("stall_hold0", 8'h31, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    op       = 2'b00;
    a        = 8'h55;
    b        = 8'h11;
    cycle();
    in_valid = 1'b0;
    chk("stall_in_ready1", 32'(in_ready), 32'(0));
    expect_out("stall_hold1", 8'h31, 1'b0, 1'b0, 1'b0);
    cycle();
    expect_out("stall_hold2", 8'h31, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'(1));
    cycle();
    expect_out("drain_b", 8'h40, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("drain_done_valid", 32'(out_valid), 32'(0));

    // Reset one cycle after acceptance discards the beat.
    send(2'b00, 8'h33, 8'h44, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b1;
    a        = 8'h99;
    cycle();
    reset    = 1'b1;
    in_valid = 1'b0;
    chk("rstmid_out_valid0", 32'(out_valid), 32'(0));
    cycle();
    chk("rstmid_out_valid1", 32'(out_valid), 32'(0));
    cycle();
    chk("rstmid_out_valid2", 32'(out_valid), 32'(0));
    send(2'b01, 8'h0F, 8'h20, 1'b1);
    chk("post_rst_lat1", 32'(out_valid), 32'(0));
    cycle();
    expect_out("post_rst", 8'h30, 1'b0, 1'b0, 1'b0);
    cycle();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      op        = 2'($urandom);
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      carry_in  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      cycle();
    end
    chk("rand_drain_pending", 32'(q.size()), 32'(0));
    chk("rand_final_valid",   32'(out_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
